// File: rtl/led_panel_ctrl_if.sv
// Host/driver-side bundle for led_panel_ctrl.
//   master : host side; drives write/load/walk/clear strobes and samples panel status.
//   slave  : controller side; receives strobes and drives panel image and status.
// The optional danger_sticky signal exists only when LED_PANEL_STICKY_EN is defined.
interface led_panel_ctrl_if #(
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 4,
  parameter int unsigned CNT_W = 16
) ();
  localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PanelW = 2 * ROWS * COLS;
  localparam int unsigned RedW   = $clog2(ROWS * COLS + 1);

  logic              wr_en;
  logic [RowW-1:0]   wr_row;
  logic [ColW-1:0]   wr_col;
  logic [1:0]        wr_val;
  logic              load_en;
  logic [PanelW-1:0] load_panel;
  logic              walk_start;
  logic              walk_all;
  logic [RowW-1:0]   walk_row;
  logic [1:0]        walk_bkgnd;
  logic              alert_clr;
  logic [PanelW-1:0] panel_out;
  logic              danger;
  logic [RedW-1:0]   red_cnt;
  logic [CNT_W-1:0]  alerts;
  logic              walk_busy;
  logic              walk_done;
`ifdef LED_PANEL_STICKY_EN
  logic              danger_sticky;
`endif

  modport master (
    output wr_en, wr_row, wr_col, wr_val, load_en, load_panel,
    output walk_start, walk_all, walk_row, walk_bkgnd, alert_clr,
    input  panel_out, danger, red_cnt, alerts, walk_busy, walk_done
`ifdef LED_PANEL_STICKY_EN
    , input danger_sticky
`endif
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_val, load_en, load_panel,
    input  walk_start, walk_all, walk_row, walk_bkgnd, alert_clr,
    output panel_out, danger, red_cnt, alerts, walk_busy, walk_done
`ifdef LED_PANEL_STICKY_EN
    , output danger_sticky
`endif
  );
endinterface

// File: rtl/led_panel_ctrl.sv
// ROWS x COLS RYGB indicator panel controller.
// Holds the panel image, applies host single-LED writes and whole-panel loads (load wins),
// runs a walking-RED self-test over one row or the whole panel, and reports RED population,
// danger and a saturating count of panel updates that contain RED.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : led_panel_ctrl_if.slave (strobes in; panel_out/danger/red_cnt/alerts/walk status out)
// Optional: define LED_PANEL_STICKY_EN to add bus.danger_sticky (set on danger, cleared by
// alert_clr or reset).
module led_panel_ctrl #(
  parameter int unsigned ROWS     = 2,
  parameter int unsigned COLS     = 4,
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned CNT_W    = 16
) (
  input logic           clk,
  input logic           rst_n,
  led_panel_ctrl_if.slave bus
);
  localparam int unsigned NLed   = ROWS * COLS;
  localparam int unsigned PanelW = 2 * NLed;
  localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RedW   = $clog2(NLed + 1);
  localparam int unsigned StepW  = (NLed > 1) ? $clog2(NLed) : 1;
  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0]  LedRed = 2'd3;

  typedef enum logic [1:0] {StIdle, StStep, StRestore} state_e;

  state_e            state_q, state_d;
  logic [PanelW-1:0] panel_q, panel_d;
  logic [CNT_W-1:0]  alerts_q, alerts_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [StepW-1:0]  step_q, step_d;
  logic              all_q, all_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [1:0]        bkgnd_q, bkgnd_d;
  logic [RedW-1:0]   red_cnt;
  logic [StepW-1:0]  last_step;

  // Walk image for a step: in single-row mode the step is the column index, in all-rows mode
  // it is the row-major LED index. Rows outside the walk keep their current value.
  function automatic logic [PanelW-1:0] step_image(input logic [PanelW-1:0] cur,
                                                   input logic all, input logic [RowW-1:0] row,
                                                   input logic [1:0] bkgnd,
                                                   input logic [StepW-1:0] step);
    logic [PanelW-1:0] img;
    logic              red;
    img = cur;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        red = all ? (StepW'(r * COLS + c) == step) : (StepW'(c) == step);
        if (all || (row == RowW'(r))) begin
          img[2*(r*COLS+c) +: 2] = red ? LedRed : bkgnd;
        end
      end
    end
    return img;
  endfunction

  function automatic logic [RedW-1:0] count_red(input logic [PanelW-1:0] img);
    logic [RedW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NLed; i++) begin
      if (img[2*i +: 2] == LedRed) n = n + RedW'(1);
    end
    return n;
  endfunction

  assign last_step = all_q ? StepW'(NLed - 1) : StepW'(COLS - 1);

  always_comb begin
    state_d = state_q;
    panel_d = panel_q;
    tick_d  = tick_q;
    step_d  = step_q;
    all_d   = all_q;
    row_d   = row_q;
    bkgnd_d = bkgnd_q;
    unique case (state_q)
      StIdle: begin
        if (bus.walk_start && (bus.walk_all || (32'(bus.walk_row) < ROWS))) begin
          all_d   = bus.walk_all;
          row_d   = bus.walk_row;
          bkgnd_d = bus.walk_bkgnd;
          tick_d  = '0;
          step_d  = '0;
          state_d = StStep;
          panel_d = step_image(panel_q, bus.walk_all, bus.walk_row, bus.walk_bkgnd, '0);
        end else if (bus.load_en) begin
          panel_d = bus.load_panel;
        end else if (bus.wr_en) begin
          // Out-of-range indices match no LED, so the write is dropped.
          for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
              if ((bus.wr_row == RowW'(r)) && (bus.wr_col == ColW'(c))) begin
                panel_d[2*(r*COLS+c) +: 2] = bus.wr_val;
              end
            end
          end
        end
      end
      StStep: begin
        if (tick_q == TickW'(TICK_DIV - 1)) begin
          tick_d = '0;
          if (step_q == last_step) begin
            state_d = StRestore;
            panel_d = {NLed{bkgnd_q}};
          end else begin
            step_d  = step_q + StepW'(1);
            panel_d = step_image(panel_q, all_q, row_q, bkgnd_q, step_q + StepW'(1));
          end
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      StRestore: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    alerts_d = alerts_q;
    if (bus.alert_clr) begin
      alerts_d = '0;
    end else if ((panel_d != panel_q) && (count_red(panel_d) != '0) && (alerts_q != '1)) begin
      alerts_d = alerts_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      panel_q  <= '0;
      alerts_q <= '0;
      tick_q   <= '0;
      step_q   <= '0;
      all_q    <= 1'b0;
      row_q    <= '0;
      bkgnd_q  <= '0;
    end else begin
      state_q  <= state_d;
      panel_q  <= panel_d;
      alerts_q <= alerts_d;
      tick_q   <= tick_d;
      step_q   <= step_d;
      all_q    <= all_d;
      row_q    <= row_d;
      bkgnd_q  <= bkgnd_d;
    end
  end

  assign red_cnt       = count_red(panel_q);
  assign bus.panel_out = panel_q;
  assign bus.red_cnt   = red_cnt;
  assign bus.danger    = (red_cnt != '0);
  assign bus.alerts    = alerts_q;
  assign bus.walk_busy = (state_q == StStep);
  assign bus.walk_done = (state_q == StRestore);

`ifdef LED_PANEL_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q | bus.danger;
    if (bus.alert_clr) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign bus.danger_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_led_panel_ctrl.sv
// Testbench for led_panel_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a frame-queue reference model of the panel.
module tb_led_panel_ctrl;
  localparam int ROWS     = 3;
  localparam int COLS     = 4;
  localparam int TICK_DIV = 10;
  localparam int CNT_W    = 3;
  localparam int NL       = ROWS * COLS;
  localparam int PW       = 2 * NL;
  localparam logic [1:0] BLU = 2'd0, GRN = 2'd1, YEL = 2'd2, RED = 2'd3;

  logic clk;
  logic rst_n;

  led_panel_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) bus ();

  led_panel_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the panel image, alert count, and a queue of frames still to be shown.
  logic [PW-1:0]    m_panel;
  logic [CNT_W-1:0] m_alerts;
  logic             m_done;
  logic             m_sticky;
  logic [PW-1:0]    m_frames[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] fill(input logic [1:0] v);
    logic [PW-1:0] f;
    for (int i = 0; i < NL; i++) f[2*i +: 2] = v;
    return f;
  endfunction

  function automatic logic [PW-1:0] put(input logic [PW-1:0] p, input int r, input int c,
                                        input logic [1:0] v);
    logic [PW-1:0] f;
    f = p;
    f[2*(r*COLS+c) +: 2] = v;
    return f;
  endfunction

  function automatic int count_red(input logic [PW-1:0] p);
    int n = 0;
    for (int i = 0; i < NL; i++) if (p[2*i +: 2] == RED) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_panel  = '0;
    m_alerts = '0;
    m_done   = 1'b0;
    m_sticky = 1'b0;
    m_frames.delete();
  endtask

  // Every walk is expanded up front into one frame per clock edge.
  task automatic plan_walk(input logic all, input int row, input logic [1:0] bk);
    logic [PW-1:0] f;
    if (all) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          f = put(fill(bk), r, c, RED);
          repeat (TICK_DIV) m_frames.push_back(f);
        end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        f = m_panel;
        for (int cc = 0; cc < COLS; cc++) f = put(f, row, cc, bk);
        f = put(f, row, c, RED);
        repeat (TICK_DIV) m_frames.push_back(f);
      end
    end
    m_frames.push_back(fill(bk));
  endtask

  task automatic model_step();
    logic [PW-1:0] nxt;
    logic          done_n;
    nxt    = m_panel;
    done_n = 1'b0;
    if (m_frames.size() != 0) begin
      nxt    = m_frames.pop_front();
      done_n = (m_frames.size() == 0);
    end else if (!m_done) begin
      if (bus.walk_start && (bus.walk_all || (int'(bus.walk_row) < ROWS))) begin
        plan_walk(bus.walk_all, int'(bus.walk_row), bus.walk_bkgnd);
        nxt = m_frames.pop_front();
      end else if (bus.load_en) begin
        nxt = bus.load_panel;
      end else if (bus.wr_en && (int'(bus.wr_row) < ROWS) && (int'(bus.wr_col) < COLS)) begin
        nxt = put(m_panel, int'(bus.wr_row), int'(bus.wr_col), bus.wr_val);
      end
    end
    m_sticky = bus.alert_clr ? 1'b0 : (m_sticky | (count_red(m_panel) != 0));
    if (bus.alert_clr) m_alerts = '0;
    else if ((nxt != m_panel) && (count_red(nxt) != 0) && (m_alerts != {CNT_W{1'b1}}))
      m_alerts = m_alerts + 1'b1;
    m_panel = nxt;
    m_done  = done_n;
  endtask

  task automatic compare_all();
    check_eq("panel_out", bus.panel_out, m_panel);
    check_eq("danger", bus.danger, count_red(m_panel) != 0);
    check_eq("red_cnt", bus.red_cnt, count_red(m_panel));
    check_eq("alerts", bus.alerts, m_alerts);
    check_eq("walk_busy", bus.walk_busy, m_frames.size() != 0);
    check_eq("walk_done", bus.walk_done, m_done);
`ifdef LED_PANEL_STICKY_EN
    check_eq("danger_sticky", bus.danger_sticky, m_sticky);
`endif
  endtask

  task automatic clear_strobes();
    bus.wr_en      = 1'b0;
    bus.load_en    = 1'b0;
    bus.walk_start = 1'b0;
    bus.alert_clr  = 1'b0;
  endtask

  // Inputs are set at a falling edge; the model takes the coming rising edge, outputs are
  // compared at the following falling edge.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
    clear_strobes();
  endtask

  task automatic do_reset();
    clear_strobes();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_walk(input logic all, input logic [1:0] row, input logic [1:0] bk);
    bus.walk_start = 1'b1;
    bus.walk_all   = all;
    bus.walk_row   = row;
    bus.walk_bkgnd = bk;
    tick();
  endtask

  task automatic load(input logic [PW-1:0] p);
    bus.load_en    = 1'b1;
    bus.load_panel = p;
    tick();
  endtask

  logic [PW-1:0] img;

  initial begin
    rst_n          = 1'b0;
    bus.wr_row     = '0;
    bus.wr_col     = '0;
    bus.wr_val     = '0;
    bus.load_panel = '0;
    bus.walk_all   = 1'b0;
    bus.walk_row   = '0;
    bus.walk_bkgnd = '0;
    clear_strobes();
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check_eq("reset_panel", bus.panel_out, 0);
    rst_n = 1'b1;

    // Loads without RED, then with RED, identical reload, single RED write.
    img = fill(BLU);
    img = put(img, 0, 0, YEL); img = put(img, 0, 2, GRN);
    img = put(img, 1, 0, GRN); img = put(img, 1, 1, YEL);
    load(img);
    check_eq("load_plain_red", bus.red_cnt, 0);
    img = put(img, 0, 1, GRN); img = put(img, 0, 2, RED); img = put(img, 1, 2, RED);
    load(img);
    check_eq("load_red_cnt", bus.red_cnt, 2);
    check_eq("load_red_alerts", bus.alerts, 1);
    load(img);
    check_eq("reload_alerts", bus.alerts, 1);
    bus.wr_en = 1'b1; bus.wr_row = 2'd1; bus.wr_col = 2'd3; bus.wr_val = RED;
    tick();
    check_eq("write_red_cnt", bus.red_cnt, 3);
    check_eq("write_alerts", bus.alerts, 2);

    // Single-row walk of row 0 over a GRN background from an all-BLU panel.
    load(fill(BLU));
    bus.alert_clr = 1'b1;
    tick();
    check_eq("clr_alerts", bus.alerts, 0);
    start_walk(1'b0, 2'd0, GRN);
    repeat (TICK_DIV * COLS) tick();
    check_eq("row_walk_done", bus.walk_done, 1);
    check_eq("row_walk_restore", bus.panel_out, fill(GRN));
    check_eq("row_walk_alerts", bus.alerts, 4);
    tick();

    // Whole-panel walk with host strobes thrown at it mid-walk.
    start_walk(1'b1, 2'd0, YEL);
    for (int i = 0; i < TICK_DIV * NL; i++) begin
      if (i == 20) begin
        bus.wr_en = 1'b1; bus.wr_row = 2'd2; bus.wr_col = 2'd1; bus.wr_val = BLU;
        bus.load_en = 1'b1; bus.load_panel = fill(GRN);
        bus.walk_start = 1'b1; bus.walk_all = 1'b0; bus.walk_row = 2'd1;
      end
      tick();
    end
    check_eq("all_walk_done", bus.walk_done, 1);
    check_eq("all_walk_restore", bus.panel_out, fill(YEL));
    tick();

    // Out-of-range walk row is rejected.
    start_walk(1'b0, 2'd3, RED);
    check_eq("bad_row_busy", bus.walk_busy, 0);
    check_eq("bad_row_panel", bus.panel_out, fill(YEL));

    // Reset in cycle 15 of a walk.
    start_walk(1'b1, 2'd0, GRN);
    repeat (14) tick();
    do_reset();
    check_eq("midwalk_rst_panel", bus.panel_out, 0);
    check_eq("midwalk_rst_busy", bus.walk_busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("midwalk_rst_nodone", bus.walk_done, 0);
    end

    // Alert saturation and clear-over-increment.
    for (int i = 0; i < 8; i++) load(put(fill(BLU), i / COLS, i % COLS, RED));
    check_eq("alerts_sat", bus.alerts, 7);
    bus.alert_clr = 1'b1;
    load(put(fill(BLU), 2, 0, RED));
    check_eq("clr_beats_inc", bus.alerts, 0);

`ifdef LED_PANEL_STICKY_EN
    load(fill(BLU));
    tick();
    check_eq("sticky_holds", bus.danger_sticky, 1);
    bus.alert_clr = 1'b1;
    tick();
    check_eq("sticky_clr", bus.danger_sticky, 0);
    tick();
    check_eq("sticky_stays_clr", bus.danger_sticky, 0);
`endif

    // Random traffic.
    for (int n = 0; n < 2500; n++) begin
      bus.wr_en  = ($urandom_range(0, 99) < 30);
      bus.wr_row = 2'($urandom_range(0, 3));
      bus.wr_col = 2'($urandom_range(0, 3));
      bus.wr_val = 2'($urandom_range(0, 3));
      bus.load_en = ($urandom_range(0, 99) < 10);
      case ($urandom_range(0, 3))
        0, 1: for (int i = 0; i < NL; i++) bus.load_panel[2*i +: 2] = 2'($urandom_range(0, 2));
        2:    bus.load_panel = PW'({$urandom, $urandom});
        default: bus.load_panel = m_panel;
      endcase
      bus.walk_start = ($urandom_range(0, 99) < 3);
      bus.walk_all   = 1'($urandom_range(0, 1));
      bus.walk_row   = 2'($urandom_range(0, 3));
      bus.walk_bkgnd = 2'($urandom_range(0, 3));
      bus.alert_clr  = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 999) < 2) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_panel_ctrl.md
Name: led_panel_ctrl

Overview:
Parametrised ROWS x COLS panel controller for RYGB indicator LEDs. Holds the panel state register and accepts single-LED writes and whole-panel loads. Contains a walking-RED self-test sequencer (one row or all rows) and danger detection with a RED population count and a saturating alert counter. Sits between the status-generation logic and the LED driver.

Parameters:
ROWS, 2, number of panel rows (>=1)
COLS, 4, number of panel columns (>=1)
TICK_DIV, 10, clock cycles each walk step is held (>=1)
CNT_W, 16, width of the ALERTS counter

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
WR_EN  in  1  single-LED write strobe
WR_ROW  in  $clog2(ROWS) (min 1)  write row index
WR_COL  in  $clog2(COLS) (min 1)  write column index
WR_VAL  in  2  LED code: BLU=0, GRN=1, YEL=2, RED=3
LOAD_EN  in  1  whole-panel load strobe
LOAD_PANEL  in  2*ROWS*COLS  panel image; LED[r][c] at bits 2*(r*COLS+c)+1 : 2*(r*COLS+c)
WALK_START  in  1  start self-test walk
WALK_ALL  in  1  1 = walk every row; 0 = walk WALK_ROW only
WALK_ROW  in  $clog2(ROWS) (min 1)  row to walk
WALK_BKGND  in  2  background LED code for the walk
ALERT_CLR  in  1  synchronous clear of ALERTS
PANEL_OUT  out  2*ROWS*COLS  registered panel state, same bit map as LOAD_PANEL
DANGER  out  1  1 when any LED in PANEL_OUT is RED
RED_CNT  out  $clog2(ROWS*COLS+1)  number of RED LEDs in PANEL_OUT
ALERTS  out  CNT_W  saturating count of panel updates containing RED
WALK_BUSY  out  1  walk in progress
WALK_DONE  out  1  one-cycle pulse at walk completion

Behaviour:
- Reset (async, RST_N=0): PANEL_OUT all BLU (0), ALERTS=0, WALK_BUSY=0, WALK_DONE=0, FSM=IDLE. DANGER=0, RED_CNT=0 follow from the panel.
- DANGER and RED_CNT: combinational from PANEL_OUT, zero added latency.
- Host writes (IDLE only): LOAD_EN has priority over WR_EN in the same cycle. Result visible on PANEL_OUT the cycle after the strobe. WR_ROW>=ROWS or WR_COL>=COLS: write ignored.
- FSM states: IDLE, STEP, RESTORE.
- IDLE -> STEP on WALK_START. Start rejected and FSM stays IDLE if WALK_ALL=0 and WALK_ROW>=ROWS. WALK_ROW, WALK_ALL and WALK_BKGND are captured at start.
- STEP, single row: the target row is set to BKGND except column k, which is RED. Other rows are unchanged. k runs 0..COLS-1, and each pattern is held TICK_DIV cycles.
- STEP, all rows: the whole panel is set to BKGND except LED[r][k], which is RED. Iteration is row-major, r=0..ROWS-1 then k=0..COLS-1, giving ROWS*COLS steps.
- STEP -> RESTORE after the last step's TICK_DIV cycles.
- RESTORE: the whole panel (all rows) is set to BKGND. WALK_DONE=1 for this cycle only. Then -> IDLE.
- Walk timing: WALK_START sampled at edge 0. Step 0 is visible from cycle 1, step n from cycle 1+n*TICK_DIV. The restore pattern and WALK_DONE appear at cycle 1+N*TICK_DIV, where N is the step count.
- WALK_BUSY=1 in STEP and 0 in IDLE/RESTORE.
- While the FSM is not IDLE: WR_EN, LOAD_EN and WALK_START are ignored (dropped, not queued).
- ALERTS increments by 1 on any edge where the next panel value differs from the current PANEL_OUT and contains at least one RED.
  - A rewrite with an identical value does not count.
  - ALERTS saturates at 2^CNT_W-1.
- ALERT_CLR has priority over increment; ALERTS=0 on the next cycle.
- Reset mid-walk: returns to IDLE immediately with reset values; no WALK_DONE pulse.

Optional Feature:
LED_PANEL_STICKY_EN
- Defined: adds output DANGER_STICKY (1 bit). It sets when DANGER=1 at a clock edge and clears only on ALERT_CLR or reset; ALERT_CLR wins if DANGER is still 1 that cycle. Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then LOAD_PANEL with row0={YEL,BLU,GRN,BLU}, row1={GRN,YEL,BLU,BLU} -> PANEL_OUT matches the next cycle; DANGER=0, RED_CNT=0, ALERTS=0.
- Load row0={YEL,GRN,RED,BLU}, row1={GRN,YEL,RED,BLU}; reload the same value; then WR_EN with row1/col3=RED -> RED_CNT=2, then 2, then 3; ALERTS=1, 1, 2.
- WALK_START with WALK_ALL=0, WALK_ROW=0, BKGND=GRN, TICK_DIV=10 from an all-BLU panel:
  - RED at row0 col k from cycle 1+10k; row1 stays BLU.
  - Cycle 41: all LEDs GRN and WALK_DONE pulses; ALERTS=4.
- WALK_ALL=1, BKGND=YEL -> 8 steps, RED visits LED[0][0]..LED[1][3] in order, WALK_DONE at cycle 81; WR_EN/LOAD_EN/WALK_START issued mid-walk have no effect.
- WALK_ROW=2 with ROWS=2 -> WALK_BUSY stays 0, panel unchanged. RST_N low at cycle 15 of a walk -> panel all BLU, WALK_BUSY=0, no WALK_DONE.
- ALERTS at 2^CNT_W-1 (CNT_W=2: three RED updates, then a fourth) -> holds at 3. Assert ALERT_CLR together with a RED update -> ALERTS=0. With LED_PANEL_STICKY_EN defined, DANGER_STICKY stays 1 after the panel returns to no RED, until ALERT_CLR.
